clmul_denetleyici: RTL and testbench
====================================

Name: clmul_denetleyici

Overview:
- Multi-cycle sequencer for the Zbc carry-less multiply operations clmul, clmulh and clmulr in the execute stage.
- Processes BIT_ADIM bits of the second operand per cycle into a 64-bit XOR accumulator. This replaces a single-cycle 32-way XOR tree, trading latency for area and timing.
- Valid/ready handshake toward the issue logic and toward writeback; flush input for pipeline kills.

Parameters:
- BIT_ADIM, 4, operand-2 bits consumed per compute cycle; legal values 1, 2, 4, 8, 16, 32.
- ADIM_SAYISI, 32/BIT_ADIM, derived number of compute cycles N; not overridable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- istek_gecerli_i  input  1  request valid.
- istek_hazir_o  output  1  controller can accept a request.
- islem_i  input  2  operation: 00 clmul, 01 clmulh, 10 clmulr, 11 reserved.
- sayi1_i  input  32  operand rs1.
- sayi2_i  input  32  operand rs2.
- temizle_i  input  1  flush; aborts any operation.
- sonuc_gecerli_o  output  1  result valid.
- sonuc_hazir_i  input  1  consumer accepts result.
- sonuc_o  output  32  selected result word.
- mesgul_o  output  1  high in HESAPLA or SONUC.

Behaviour:
- Reset (async, rst_ni=0):
  - State BOSTA.
  - Accumulator, operand registers, counter and sonuc_o are 0.
  - sonuc_gecerli_o=0, mesgul_o=0.
  - istek_hazir_o=1 once rst_ni is released.
- Reset asserted mid-operation discards all state immediately; no result is ever presented.
- States: BOSTA, HESAPLA, SONUC.
- istek_hazir_o = (state==BOSTA) & ~temizle_i. Acceptance is istek_gecerli_i & istek_hazir_o at a rising edge T.
- On acceptance:
  - Latch sayi1 and islem into registers; load sayi2 into a right-shift register.
  - Clear the accumulator and counter.
  - Go to HESAPLA.
- Zero shortcut: if sayi1_i==0 or sayi2_i==0 at acceptance, go directly to SONUC with result 0.
- HESAPLA, each edge:
  - acc ^= XOR over k in [0,BIT_ADIM) of (b[k] ? a << (sayac*BIT_ADIM+k) : 0).
  - Shift b right by BIT_ADIM; increment sayac.
  - After the N-th step, go to SONUC.
- Latency:
  - Normal path: sonuc_gecerli_o first high in the cycle after edge T+N (N+1 edges after acceptance). With BIT_ADIM=4, that is 9 edges.
  - Zero shortcut: 1 edge.
- SONUC:
  - sonuc_gecerli_o=1. sonuc_o is registered and held stable while sonuc_hazir_i=0; there is no timeout.
  - Result selection: clmul → acc[31:0]; clmulh → acc[63:32]; clmulr → acc[62:31]; reserved 11 → 0.
  - On sonuc_gecerli_o & sonuc_hazir_i, go to BOSTA.
  - No new request is accepted in the same cycle (one-bubble turnaround).
- Flush:
  - temizle_i=1 in any state forces BOSTA at the next edge and clears sonuc_gecerli_o. It takes priority over both handshakes.
  - A flushed result never appears; a result handshaken in the same cycle as a flush is not delivered.
- Width rules:
  - The accumulator is 64-bit; the shifted operand is zero-extended to 64 bits before XOR.
  - The counter is ceil(log2(N+1)) bits and never wraps in valid operation.
- Inputs sayi1_i, sayi2_i and islem_i are ignored except at acceptance.

Decomposition:
- Shared package clmul_paket:
  - opcode constants CLMUL=2'b00, CLMULH=2'b01, CLMULR=2'b10;
  - state encoding BOSTA/HESAPLA/SONUC;
  - default BIT_ADIM.
- Sub-module clmul_adim (combinational):
  - inputs: acc[63:0], a[31:0], b_parca[BIT_ADIM-1:0], base offset;
  - output: next acc;
  - instantiated once inside the controller.
- FSM, counter, handshake logic and result mux stay in clmul_denetleyici.

Test Plan:
- Basic: clmul, sayi1=0x3, sayi2=0x3, sonuc_hazir_i=1 → sonuc_o=0x00000005 with sonuc_gecerli_o after exactly 9 edges (BIT_ADIM=4); istek_hazir_o low throughout.
- Upper and reversed halves: sayi1=sayi2=0x80000000 → clmul 0x00000000, clmulh 0x40000000, clmulr 0x80000000.
- All-ones: sayi1=sayi2=0xFFFFFFFF → clmul 0x55555555, clmulh 0x55555555, clmulr 0xAAAAAAAA; repeat with BIT_ADIM=1 (33 edges) and BIT_ADIM=32 (2 edges).
- Zero shortcut and backpressure: sayi2=0 → valid after 1 edge, sonuc_o=0. Then sayi1=0x12345678, sayi2=0x1 with sonuc_hazir_i low for 5 cycles → clmul result 0x12345678 held stable; one-bubble return to istek_hazir_o=1.
- Flush and reset:
  - temizle_i pulsed at HESAPLA step 3 → BOSTA next edge, no sonuc_gecerli_o.
  - temizle_i and sonuc_hazir_i together in SONUC → result dropped.
  - rst_ni pulsed low mid-HESAPLA → all outputs 0 immediately; next request computes correctly.
- Reserved opcode 11 with nonzero operands → sonuc_o=0 with normal latency; random back-to-back traffic checked against a reference model for 10k operations.

Source files
------------

// File: rtl/clmul_paket.sv
// Shared definitions for the multi-cycle carry-less multiply sequencer.
package clmul_paket;

    localparam int unsigned VARSAYILAN_BIT_ADIM = 4;
    localparam int unsigned VERI_W              = 32;
    localparam int unsigned ACC_W               = 64;
    localparam int unsigned OFS_W               = 6;

    localparam logic [1:0] CLMUL  = 2'b00;
    localparam logic [1:0] CLMULH = 2'b01;
    localparam logic [1:0] CLMULR = 2'b10;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        SONUC   = 2'd2
    } durum_e;

    // Picks the architectural result word out of the 64-bit product.
    function automatic logic [VERI_W-1:0] sonuc_sec(input logic [1:0]       islem,
                                                    input logic [ACC_W-1:0] acc);
        logic [VERI_W-1:0] r;
        case (islem)
            CLMUL:   r = acc[31:0];
            CLMULH:  r = acc[63:32];
            CLMULR:  r = acc[62:31];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clmul_denetleyici_adim.sv
// One compute step: folds BIT_ADIM partial products of a into the accumulator.
module clmul_adim
    import clmul_paket::*;
#(
    parameter int unsigned BIT_ADIM = VARSAYILAN_BIT_ADIM
) (
    input  logic [ACC_W-1:0]    acc_i,
    input  logic [VERI_W-1:0]   a_i,
    input  logic [BIT_ADIM-1:0] b_parca_i,
    input  logic [OFS_W-1:0]    taban_i,
    output logic [ACC_W-1:0]    acc_o
);

    logic [ACC_W-1:0] a_genis;

    assign a_genis = {{(ACC_W-VERI_W){1'b0}}, a_i};

    always_comb begin
        acc_o = acc_i;
        for (int unsigned k = 0; k < BIT_ADIM; k++) begin
            if (b_parca_i[k]) begin
                acc_o = acc_o ^ (a_genis << (taban_i + OFS_W'(k)));
            end
        end
    end

endmodule

// File: rtl/clmul_denetleyici.sv
// clmul/clmulh/clmulr sequencer: BIT_ADIM bits of rs2 per cycle into a 64-bit XOR accumulator.
module clmul_denetleyici
    import clmul_paket::*;
#(
    parameter int unsigned BIT_ADIM = VARSAYILAN_BIT_ADIM
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              istek_gecerli_i,
    output logic              istek_hazir_o,
    input  logic [1:0]        islem_i,
    input  logic [VERI_W-1:0] sayi1_i,
    input  logic [VERI_W-1:0] sayi2_i,
    input  logic              temizle_i,
    output logic              sonuc_gecerli_o,
    input  logic              sonuc_hazir_i,
    output logic [VERI_W-1:0] sonuc_o,
    output logic              mesgul_o
);

    localparam int unsigned ADIM_SAYISI = VERI_W / BIT_ADIM;
    localparam int unsigned SAYAC_W     = $clog2(ADIM_SAYISI + 1);

    durum_e              durum_q, durum_d;
    logic [VERI_W-1:0]   a_q, a_d;
    logic [VERI_W-1:0]   b_q, b_d;
    logic [1:0]          islem_q, islem_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [SAYAC_W-1:0]  sayac_q, sayac_d;
    logic [VERI_W-1:0]   sonuc_q, sonuc_d;
    logic                gecerli_q;
    logic                mesgul_q;

    logic [ACC_W-1:0]    acc_sonraki;
    logic [OFS_W-1:0]    taban;
    logic                son_adim;
    logic                kabul;

    assign istek_hazir_o   = rst_ni & (durum_q == BOSTA) & ~temizle_i;
    assign kabul           = istek_gecerli_i & istek_hazir_o;
    assign taban           = OFS_W'(32'(sayac_q) * BIT_ADIM);
    assign son_adim        = (sayac_q == SAYAC_W'(ADIM_SAYISI - 1));
    assign sonuc_gecerli_o = gecerli_q;
    assign mesgul_o        = mesgul_q;
    assign sonuc_o         = sonuc_q;

    clmul_adim #(
        .BIT_ADIM (BIT_ADIM)
    ) u_adim (
        .acc_i     (acc_q),
        .a_i       (a_q),
        .b_parca_i (b_q[BIT_ADIM-1:0]),
        .taban_i   (taban),
        .acc_o     (acc_sonraki)
    );

    // Next-state and datapath update; flush overrides everything else.
    always_comb begin
        durum_d = durum_q;
        a_d     = a_q;
        b_d     = b_q;
        islem_d = islem_q;
        acc_d   = acc_q;
        sayac_d = sayac_q;
        sonuc_d = sonuc_q;

        case (durum_q)
            BOSTA: begin
                if (kabul) begin
                    a_d     = sayi1_i;
                    b_d     = sayi2_i;
                    islem_d = islem_i;
                    acc_d   = '0;
                    sayac_d = '0;
                    if ((sayi1_i == '0) || (sayi2_i == '0)) begin
                        sonuc_d = '0;
                        durum_d = SONUC;
                    end else begin
                        durum_d = HESAPLA;
                    end
                end
            end
            HESAPLA: begin
                acc_d   = acc_sonraki;
                b_d     = b_q >> BIT_ADIM;
                sayac_d = sayac_q + SAYAC_W'(1);
                if (son_adim) begin
                    sonuc_d = sonuc_sec(islem_q, acc_sonraki);
                    durum_d = SONUC;
                end
            end
            SONUC: begin
                if (sonuc_hazir_i) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase

        if (temizle_i) begin
            durum_d = BOSTA;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q   <= BOSTA;
            a_q       <= '0;
            b_q       <= '0;
            islem_q   <= '0;
            acc_q     <= '0;
            sayac_q   <= '0;
            sonuc_q   <= '0;
            gecerli_q <= 1'b0;
            mesgul_q  <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            a_q       <= a_d;
            b_q       <= b_d;
            islem_q   <= islem_d;
            acc_q     <= acc_d;
            sayac_q   <= sayac_d;
            sonuc_q   <= sonuc_d;
            gecerli_q <= (durum_d == SONUC);
            mesgul_q  <= (durum_d != BOSTA);
        end
    end

endmodule

// File: tb/tb_clmul_denetleyici.sv
// Bench for clmul_denetleyici: three step widths (4, 1, 32) against a timing/product model.
module tb_clmul_denetleyici;

    logic        clk;
    logic        rst_n;
    logic        gecerli   [3];
    logic        ist_hazir [3];
    logic [1:0]  islem     [3];
    logic [31:0] s1        [3];
    logic [31:0] s2        [3];
    logic        temizle   [3];
    logic        son_gec   [3];
    logic        son_hazir [3];
    logic [31:0] sonuc     [3];
    logic        mesgul    [3];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    clmul_denetleyici #(.BIT_ADIM(4)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .istek_gecerli_i(gecerli[0]), .istek_hazir_o(ist_hazir[0]),
        .islem_i(islem[0]), .sayi1_i(s1[0]), .sayi2_i(s2[0]), .temizle_i(temizle[0]),
        .sonuc_gecerli_o(son_gec[0]), .sonuc_hazir_i(son_hazir[0]), .sonuc_o(sonuc[0]), .mesgul_o(mesgul[0]));
    clmul_denetleyici #(.BIT_ADIM(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .istek_gecerli_i(gecerli[1]), .istek_hazir_o(ist_hazir[1]),
        .islem_i(islem[1]), .sayi1_i(s1[1]), .sayi2_i(s2[1]), .temizle_i(temizle[1]),
        .sonuc_gecerli_o(son_gec[1]), .sonuc_hazir_i(son_hazir[1]), .sonuc_o(sonuc[1]), .mesgul_o(mesgul[1]));
    clmul_denetleyici #(.BIT_ADIM(32)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .istek_gecerli_i(gecerli[2]), .istek_hazir_o(ist_hazir[2]),
        .islem_i(islem[2]), .sayi1_i(s1[2]), .sayi2_i(s2[2]), .temizle_i(temizle[2]),
        .sonuc_gecerli_o(son_gec[2]), .sonuc_hazir_i(son_hazir[2]), .sonuc_o(sonuc[2]), .mesgul_o(mesgul[2]));

    // Reference product: full 32x32 carry-less multiply, then word selection.
    function automatic logic [31:0] ref_sonuc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'd0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) p = p ^ (64'(a) << i);
        end
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return p[62:31];
            default: return 32'd0;
        endcase
    endfunction

    function automatic int adim_n(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 32 : 1);
    endfunction

    // Model: busy/valid flags, edges left until the result shows, and the result word.
    logic        m_mesgul  [3];
    logic        m_gecerli [3];
    int          m_kalan   [3];
    logic [31:0] m_bekleyen[3];
    logic [31:0] m_sonuc   [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_mesgul[i]   <= 1'b0;
                m_gecerli[i]  <= 1'b0;
                m_kalan[i]    <= 0;
                m_bekleyen[i] <= 32'd0;
                m_sonuc[i]    <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (temizle[i]) begin
                    m_mesgul[i]  <= 1'b0;
                    m_gecerli[i] <= 1'b0;
                end else if (!m_mesgul[i]) begin
                    if (gecerli[i]) begin
                        m_mesgul[i] <= 1'b1;
                        if (s1[i] == 32'd0 || s2[i] == 32'd0) begin
                            m_gecerli[i] <= 1'b1;
                            m_sonuc[i]   <= 32'd0;
                        end else begin
                            m_kalan[i]    <= adim_n(i);
                            m_bekleyen[i] <= ref_sonuc(islem[i], s1[i], s2[i]);
                        end
                    end
                end else if (!m_gecerli[i]) begin
                    m_kalan[i] <= m_kalan[i] - 1;
                    if (m_kalan[i] == 1) begin
                        m_gecerli[i] <= 1'b1;
                        m_sonuc[i]   <= m_bekleyen[i];
                    end
                end else if (son_hazir[i]) begin
                    m_mesgul[i]  <= 1'b0;
                    m_gecerli[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", ad, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d istek_hazir", i), 32'(ist_hazir[i]),
                32'(rst_n && !m_mesgul[i] && !temizle[i]));
            chk($sformatf("u%0d sonuc_gecerli", i), 32'(son_gec[i]), 32'(m_gecerli[i]));
            chk($sformatf("u%0d mesgul", i), 32'(mesgul[i]), 32'(m_mesgul[i]));
            if (m_gecerli[i]) chk($sformatf("u%0d sonuc", i), sonuc[i], m_sonuc[i]);
        end
    end

    task automatic istek(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        gecerli[i] = 1'b1;
        islem[i]   = op;
        s1[i]      = a;
        s2[i]      = b;
    endtask

    // Counts edges from acceptance until valid is seen; bounded.
    task automatic bekle(input int i, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) gecerli[i] = 1'b0;
        end while (!son_gec[i] && n < 100);
        if (!son_gec[i]) begin
            tests++;
            fails++;
            $display("FAIL u%0d timeout: got no valid, expected valid within 100 edges", i);
        end
    endtask

    task automatic calistir(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int lat);
        int n;
        son_hazir[i] = 1'b1;
        istek(i, op, a, b);
        bekle(i, n);
        chk($sformatf("u%0d gecikme", i), 32'(n), 32'(lat));
        chk($sformatf("u%0d sonuc_literal", i), sonuc[i], exp);
        @(posedge clk); #1;
        chk($sformatf("u%0d bubble_hazir", i), 32'(ist_hazir[i]), 32'd1);
    endtask

    initial begin
        int n;
        int goruldu;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gecerli[i] = 1'b0; islem[i] = 2'b00; s1[i] = 32'd0; s2[i] = 32'd0;
            temizle[i] = 1'b0; son_hazir[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset sonuc", sonuc[0], 32'd0);
        chk("reset gecerli", 32'(son_gec[0]), 32'd0);
        chk("reset mesgul", 32'(mesgul[0]), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset sonrasi hazir", 32'(ist_hazir[0]), 32'd1);
        @(posedge clk); #1;

        calistir(0, 2'b00, 32'h3, 32'h3, 32'h00000005, 9);
        calistir(0, 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 9);
        calistir(0, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 9);
        calistir(0, 2'b10, 32'h80000000, 32'h80000000, 32'h80000000, 9);
        calistir(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 9);
        calistir(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 9);
        calistir(0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 9);
        calistir(1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 33);
        calistir(1, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 33);
        calistir(2, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 2);
        calistir(2, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 2);
        calistir(0, 2'b00, 32'h12345678, 32'h0, 32'h00000000, 1);
        calistir(0, 2'b11, 32'h12345678, 32'h9ABCDEF1, 32'h00000000, 9);

        // Backpressure: result held while the consumer stalls.
        son_hazir[0] = 1'b0;
        istek(0, 2'b00, 32'h12345678, 32'h1);
        bekle(0, n);
        chk("bp gecikme", 32'(n), 32'd9);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp sonuc sabit", sonuc[0], 32'h12345678);
            chk("bp gecerli sabit", 32'(son_gec[0]), 32'd1);
        end
        son_hazir[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp bitti gecerli", 32'(son_gec[0]), 32'd0);
        chk("bp bubble hazir", 32'(ist_hazir[0]), 32'd1);

        // Flush during the third compute step.
        istek(0, 2'b00, 32'h5, 32'h7);
        @(posedge clk); #1; gecerli[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        temizle[0] = 1'b1;
        @(posedge clk); #1;
        temizle[0] = 1'b0;
        chk("flush mesgul", 32'(mesgul[0]), 32'd0);
        goruldu = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (son_gec[0]) goruldu++;
        end
        chk("flush sonuc yok", 32'(goruldu), 32'd0);

        // Flush coinciding with the result handshake.
        son_hazir[0] = 1'b0;
        istek(0, 2'b01, 32'hDEADBEEF, 32'h0F0F0F0F);
        bekle(0, n);
        temizle[0] = 1'b1; son_hazir[0] = 1'b1;
        @(posedge clk); #1;
        temizle[0] = 1'b0;
        chk("flush+hs gecerli", 32'(son_gec[0]), 32'd0);
        chk("flush+hs mesgul", 32'(mesgul[0]), 32'd0);

        // Asynchronous reset mid-compute.
        istek(0, 2'b00, 32'hA5A5A5A5, 32'h3);
        @(posedge clk); #1; gecerli[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst mid sonuc", sonuc[0], 32'd0);
        chk("rst mid gecerli", 32'(son_gec[0]), 32'd0);
        chk("rst mid mesgul", 32'(mesgul[0]), 32'd0);
        chk("rst mid hazir", 32'(ist_hazir[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        calistir(0, 2'b00, 32'h3, 32'h3, 32'h00000005, 9);

        // Random back-to-back traffic on all three widths.
        for (int c = 0; c < 25000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                gecerli[i]   = ($urandom_range(0, 3) != 0);
                islem[i]     = 2'($urandom);
                s1[i]        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                s2[i]        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                son_hazir[i] = ($urandom_range(0, 3) != 0);
                temizle[i]   = ($urandom_range(0, 63) == 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            gecerli[i] = 1'b0; temizle[i] = 1'b0; son_hazir[i] = 1'b1;
        end
        repeat (40) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
